fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..16).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  response valid.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode consumes.
- out_pc  out  XLEN  PC of out_instr.
- out_instr  out  32  instruction.
- out_pc_plus4  out  XLEN  out_pc+4, modulo 2^XLEN.

Function
REQ-005 SHALL accept a request when imem_req_valid && imem_req_ready, then advance fetch_pc by 4 (wrap modulo 2^XLEN).
REQ-006 SHALL return responses in request order, exactly one per accepted request, each no earlier than the cycle after acceptance.
REQ-007 SHALL assert imem_req_valid only in RUN with outstanding + queue_count < DEPTH (credit rule; the queue never overflows).
REQ-008 SHALL tag each accepted request with its address in an in-order PC FIFO of DEPTH entries and pair that tag with the matching response.
REQ-009 SHALL present the queue head on out_*; pop on out_valid && out_ready; out_valid = queue non-empty (plus REQ-019 bypass).
REQ-010 SHALL support simultaneous push and pop in one cycle when the queue is full or empty, with no change in count.
REQ-011 FSM states: RUN, DRAIN.
REQ-012 On redirect_valid: flush queue, set fetch_pc = redirect_pc, drop_count = outstanding (excluding any request accepted that cycle, which is also dropped); go to DRAIN if drop_count > 0, else stay in RUN.
REQ-013 In DRAIN: no requests; each response decrements drop_count and is discarded; when drop_count reaches 0, go to RUN next cycle.
REQ-014 Redirect has priority over same-cycle response, pop, and request; the same-cycle response counts toward drop.
REQ-015 redirect_pc[1:0] SHALL be forced to 2'b00.
REQ-016 Redirect while in DRAIN: reload fetch_pc; drop_count unchanged (no new outstanding).

Reset
REQ-017 While rst is low: state = RUN, fetch_pc = RESET_PC, queue empty, outstanding = 0, drop_count = 0, imem_req_valid = 0, out_valid = 0, out_pc/out_instr/out_pc_plus4 = 0.
REQ-018 After rst deasserts, imem_req_valid SHALL assert no earlier than the first clk edge; reset mid-operation discards all in-flight state.

Configuration
REQ-019 Macro FETCH_BYPASS_EN: if defined, when the queue is empty and a non-dropped response arrives, out_* present it combinationally in the same cycle, and it is not enqueued if out_ready is high. If undefined, every response is enqueued first (minimum one-cycle response-to-out_valid latency).

Structure
REQ-020 Shared package fetch_pkg SHALL hold the RUN/DRAIN state enum, the INSTR_W=32 constant, and the queue entry struct {pc, instr}.
REQ-021 One sub-module, sync_fifo (parametrised width/depth, async active-low reset), SHALL implement both the instruction queue and the PC tag FIFO.

Verification
REQ-022 Reset, ready=1, 1-cycle memory: addresses 0x0, 0x4, 0x8 are issued on consecutive cycles; out_pc sequence is 0x0, 0x4, 0x8 with out_pc_plus4 = 0x4, 0x8, 0xC.
REQ-023 out_ready=0, DEPTH=4: exactly 4 requests are accepted, then imem_req_valid=0; one pop re-enables exactly one request.
REQ-024 Redirect to 0x100 with 2 outstanding: enters DRAIN, 2 responses are dropped, next request is 0x100, and first out_pc is 0x100.
REQ-025 Redirect to 0x203 in the same cycle as response and pop: fetch address 0x200, queue empty next cycle.
REQ-026 fetch_pc = 0xFFFF_FFFC: next request wraps to 0x0; out_pc_plus4 = 0x0.
REQ-027 With FETCH_BYPASS_EN, empty queue: response at cycle N gives out_valid=1 in cycle N; without it, out_valid=1 in N+1.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_pkg                                                 |
// | Brief    : Shared types and constants for the instruction fetch unit |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fetch_pkg;

   // Fetch control states: RUN issues requests, DRAIN discards stale responses
   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } fetch_state_t;

   // Instruction word width
   localparam int INSTR_W = 32;

   // Widest PC the entry view can carry; narrower PCs are zero-extended
   localparam int PC_W_MAX = 64;

   // One instruction queue entry: the fetch address and the word returned for it
   typedef struct packed {
      logic [PC_W_MAX-1:0] pc;
      logic [INSTR_W-1:0]  instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sync_fifo                                                 |
// | Brief    : Single-clock FIFO with show-ahead head, occupancy count   |
// |            and synchronous flush. DEPTH must be a power of two.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sync_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_empty;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   // A full FIFO still takes a push when the head leaves in the same cycle
   always_comb begin
      w_empty   = (r_count == '0);
      w_full    = (r_count == CW'(DEPTH));
      w_do_pop  = pop && !w_empty;
      w_do_push = push && (!w_full || w_do_pop);
   end

   // Storage array; contents need no reset because the count qualifies them
   always_ff @(posedge clk) begin
      if (w_do_push && !flush) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign head_data = r_mem[r_rd_ptr];
   assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_unit                                                |
// | Brief    : In-order instruction fetch with credit-based request      |
// |            issue, PC tag FIFO, instruction queue and redirect drain. |
// |            Build macro FETCH_BYPASS_EN: present a response to decode |
// |            in its arrival cycle when the instruction queue is empty. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic [XLEN-1:0]    out_pc_plus4
);

   localparam int CW = $clog2(DEPTH) + 1;

`ifdef FETCH_BYPASS_EN
   localparam logic c_bypass_en = 1'b1;
`else
   localparam logic c_bypass_en = 1'b0;
`endif

   fetch_state_t            r_state;
   fetch_state_t            w_state_nx;
   logic [XLEN-1:0]         r_fetch_pc;
   logic [XLEN-1:0]         w_fetch_pc_nx;
   logic [CW-1:0]           r_drop_count;
   logic [CW-1:0]           w_drop_nx;
   logic                    r_started;

   logic [CW-1:0]           w_outstanding;
   logic [CW-1:0]           w_q_count;
   logic [XLEN-1:0]         w_tag_pc;
   logic [XLEN+INSTR_W-1:0] w_q_head;
   logic                    w_req_fire;
   logic                    w_rsp_in;
   logic                    w_rsp_keep;
   logic                    w_q_empty;
   logic                    w_credit_ok;
   logic                    w_bypass;
   logic                    w_q_push;
   logic                    w_q_pop;
   fetch_entry_t            w_rsp_entry;
   fetch_entry_t            w_head_entry;
   fetch_entry_t            w_out_entry;
   logic                    w_unused_pc_hi;

   // Every accepted request holds a tag until its response returns, so the
   // tag FIFO occupancy is the outstanding-request count.
   sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .push      (w_req_fire),
      .push_data (r_fetch_pc),
      .pop       (w_rsp_in),
      .head_data (w_tag_pc),
      .count     (w_outstanding)
   );

   sync_fifo #(
      .WIDTH (XLEN + INSTR_W),
      .DEPTH (DEPTH)
   ) u_instr_q (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (w_q_push),
      .push_data ({w_tag_pc, imem_rsp_data}),
      .pop       (w_q_pop),
      .head_data (w_q_head),
      .count     (w_q_count)
   );

   // Responses only count when something is in flight
   assign w_rsp_in    = imem_rsp_valid && (w_outstanding != '0);
   // Issue only while in-flight plus queued words leave a free queue slot
   assign w_credit_ok = ({1'b0, w_outstanding} + {1'b0, w_q_count}) < (CW+1)'(DEPTH);
   assign imem_req_addr = r_fetch_pc;

   // State, fetch PC and drop counter registers; r_started holds off issue until the first edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_RUN;
         r_fetch_pc   <= RESET_PC;
         r_drop_count <= '0;
         r_started    <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_fetch_pc   <= w_fetch_pc_nx;
         r_drop_count <= w_drop_nx;
         r_started    <= 1'b1;
      end
   end

   // Next-state logic: redirect wins over issue and response handling
   always_comb begin
      w_state_nx     = r_state;
      w_fetch_pc_nx  = r_fetch_pc;
      w_drop_nx      = r_drop_count;
      imem_req_valid = 1'b0;
      w_req_fire     = 1'b0;
      if (redirect_valid) begin
         w_fetch_pc_nx = {redirect_pc[XLEN-1:2], 2'b00};
         w_drop_nx     = w_outstanding - CW'(w_rsp_in);
         w_state_nx    = (w_drop_nx != '0) ? ST_DRAIN : ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               imem_req_valid = r_started && w_credit_ok;
               w_req_fire     = imem_req_valid && imem_req_ready;
               if (w_req_fire) begin
                  w_fetch_pc_nx = r_fetch_pc + XLEN'(4);
               end
            end
            ST_DRAIN: begin
               if (w_rsp_in) begin
                  w_drop_nx = r_drop_count - CW'(1);
                  if (w_drop_nx == '0) begin
                     w_state_nx = ST_RUN;
                  end
               end
            end
            default: w_state_nx = ST_RUN;
         endcase
      end
   end

   // Queue control: keep live responses, optionally bypass into an empty queue
   always_comb begin
      w_rsp_keep = w_rsp_in && (r_state == ST_RUN) && !redirect_valid;
      w_q_empty  = (w_q_count == '0);
      w_bypass   = c_bypass_en && w_q_empty && w_rsp_keep;
      w_q_push   = w_rsp_keep && !(w_bypass && out_ready);
      w_q_pop    = !w_q_empty && out_ready && !redirect_valid;
   end

   // Decode-side view: queue head, else the bypassed response, else all zero
   always_comb begin
      w_rsp_entry.pc     = PC_W_MAX'(w_tag_pc);
      w_rsp_entry.instr  = imem_rsp_data;
      w_head_entry.pc    = PC_W_MAX'(w_q_head[XLEN+INSTR_W-1:INSTR_W]);
      w_head_entry.instr = w_q_head[INSTR_W-1:0];
      w_out_entry        = '0;
      out_valid          = !w_q_empty || w_bypass;
      if (!w_q_empty) begin
         w_out_entry = w_head_entry;
      end else if (w_bypass) begin
         w_out_entry = w_rsp_entry;
      end
      out_pc       = w_out_entry.pc[XLEN-1:0];
      out_instr    = w_out_entry.instr;
      out_pc_plus4 = out_valid ? (out_pc + XLEN'(4)) : '0;
   end

   // Upper entry PC bits are zero-extension only
   assign w_unused_pc_hi = ^w_out_entry.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                             |
// | Brief    : Self-checking bench for fetch_unit (table + sequences).   |
// |            Expectations follow FETCH_BYPASS_EN when it is defined.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_pc_plus4;

   fetch_unit #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_pc_plus4   (out_pc_plus4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rdy;
      logic        ordy;
      logic        men;
      logic        e_req_v;
      logic [31:0] e_req_addr;
      logic        e_out_v;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [31:0] e_p4;
   } vec_t;

   vec_t        vecs [6];
   logic [31:0] pq [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   logic        s_req_v;
   logic [31:0] s_req_addr;
   logic        s_fire;
   logic        s_out_v;
   logic [31:0] s_out_pc;
   logic [31:0] s_out_instr;
   logic [31:0] s_out_p4;

   task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk_b(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", nm, act, exp);
      end
   endtask

   // One clock cycle, entered and left at a falling edge. The memory model
   // answers in order, one response per cycle while men is high, with data
   // equal to the address XOR 0xDEAD0000.
   task automatic run_cycle(input logic rdy, input logic ordy, input logic men,
                            input logic redir, input logic [31:0] rpc);
      imem_req_ready = rdy;
      out_ready      = ordy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (men && pq.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = pq[0] ^ 32'hDEAD_0000;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      #1;
      s_req_v     = imem_req_valid;
      s_req_addr  = imem_req_addr;
      s_fire      = imem_req_valid && imem_req_ready;
      s_out_v     = out_valid;
      s_out_pc    = out_pc;
      s_out_instr = out_instr;
      s_out_p4    = out_pc_plus4;
      @(posedge clk);
      if (imem_rsp_valid) void'(pq.pop_front());
      if (s_fire) pq.push_back(s_req_addr);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      pq.delete();
      @(negedge clk);
      @(negedge clk);
      chk_b("rst_req_valid", imem_req_valid, 1'b0);
      chk_b("rst_out_valid", out_valid, 1'b0);
      chk_w("rst_out_pc", out_pc, 32'h0);
      chk_w("rst_out_instr", out_instr, 32'h0);
      chk_w("rst_out_pc_plus4", out_pc_plus4, 32'h0);
      rst = 1'b1;
   endtask

   task automatic wait_out(input string nm, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic [31:0] e_p4);
      int   k   = 0;
      logic got = 1'b0;
      while (!got && k < 6) begin
         run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         got = s_out_v;
         k++;
      end
      chk_b({nm, "_seen"}, got, 1'b1);
      if (got) begin
         chk_w({nm, "_pc"}, s_out_pc, e_pc);
         chk_w({nm, "_instr"}, s_out_instr, e_instr);
         chk_w({nm, "_pc_plus4"}, s_out_p4, e_p4);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          nf;
      logic [31:0] last_addr;

      // Free-running fetch from reset with a 1-cycle memory
      vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
`ifdef FETCH_BYPASS_EN
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0, 32'hDEAD_0000, 32'h4};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4, 32'hDEAD_0004, 32'h8};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8, 32'hDEAD_0008, 32'hC};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 32'hDEAD_000C, 32'h10};
`else
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0, 32'h0,         32'h0};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0, 32'hDEAD_0000, 32'h4};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4, 32'hDEAD_0004, 32'h8};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'hDEAD_0008, 32'hC};
`endif

      do_reset();
      for (int i = 0; i < 6; i++) begin
         run_cycle(vecs[i].rdy, vecs[i].ordy, vecs[i].men, 1'b0, 32'h0);
         chk_b($sformatf("vec%0d_req_valid", i), s_req_v, vecs[i].e_req_v);
         if (vecs[i].e_req_v)
            chk_w($sformatf("vec%0d_req_addr", i), s_req_addr, vecs[i].e_req_addr);
         chk_b($sformatf("vec%0d_out_valid", i), s_out_v, vecs[i].e_out_v);
         if (vecs[i].e_out_v) begin
            chk_w($sformatf("vec%0d_out_pc", i), s_out_pc, vecs[i].e_pc);
            chk_w($sformatf("vec%0d_out_instr", i), s_out_instr, vecs[i].e_instr);
            chk_w($sformatf("vec%0d_out_pc_plus4", i), s_out_p4, vecs[i].e_p4);
         end
      end

      // Backpressure: four credits, then one pop frees exactly one request
      do_reset();
      nf = 0;
      for (int i = 0; i < 10; i++) begin
         run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
         if (s_fire) nf++;
      end
      chk_w("bp_accepts", 32'(nf), 32'd4);
      chk_b("bp_req_valid_low", s_req_v, 1'b0);
      chk_b("bp_out_valid", s_out_v, 1'b1);
      chk_w("bp_head_pc", s_out_pc, 32'h0);
      nf        = 0;
      last_addr = 32'hFFFF_FFFF;
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_w("bp_pop_pc", s_out_pc, 32'h0);
      if (s_fire) begin nf++; last_addr = s_req_addr; end
      for (int i = 0; i < 7; i++) begin
         run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
         if (s_fire) begin nf++; last_addr = s_req_addr; end
      end
      chk_w("bp_refill_accepts", 32'(nf), 32'd1);
      chk_w("bp_refill_addr", last_addr, 32'h10);
      chk_w("bp_new_head_pc", s_out_pc, 32'h4);

      // Redirect to 0x100 with two requests in flight
      do_reset();
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
      chk_b("rd_no_req_redirect", s_req_v, 1'b0);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_b("rd_drain1_req", s_req_v, 1'b0);
      chk_b("rd_drain1_out", s_out_v, 1'b0);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_b("rd_drain2_req", s_req_v, 1'b0);
      chk_b("rd_drain2_out", s_out_v, 1'b0);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_b("rd_resume_req", s_req_v, 1'b1);
      chk_w("rd_resume_addr", s_req_addr, 32'h100);
      wait_out("rd_first_out", 32'h100, 32'hDEAD_0100, 32'h104);

      // Redirect to 0x203 together with a response and a pop
      do_reset();
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h203);
      run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      chk_b("rx_queue_empty", s_out_v, 1'b0);
      chk_b("rx_req_valid", s_req_v, 1'b1);
      chk_w("rx_req_addr", s_req_addr, 32'h200);
      wait_out("rx_first_out", 32'h200, 32'hDEAD_0200, 32'h204);

      // Address wrap at the top of the space
      do_reset();
      run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      chk_b("wr_no_req_first_cycle", s_req_v, 1'b0);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_w("wr_req_addr_top", s_req_addr, 32'hFFFF_FFFC);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_b("wr_req_valid_wrap", s_req_v, 1'b1);
      chk_w("wr_req_addr_wrap", s_req_addr, 32'h0);
`ifdef FETCH_BYPASS_EN
      chk_b("wr_bypass_same_cycle", s_out_v, 1'b1);
      chk_w("wr_bypass_pc", s_out_pc, 32'hFFFF_FFFC);
      chk_w("wr_bypass_pc_plus4", s_out_p4, 32'h0);
`else
      chk_b("wr_no_bypass_same_cycle", s_out_v, 1'b0);
      wait_out("wr_top_out", 32'hFFFF_FFFC, 32'h2152_FFFC, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
